// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle sequencer and decoder for the 24-bit MIPS-style datapath
// Optional feature macro: MC_ILLEGAL_TRAP_EN (illegal opcode halts and sets sticky illegal flag)
module mc_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] instr_in,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic [2:0]  Ra,
  output logic [2:0]  Rb,
  output logic [2:0]  Rw,
  output logic        enWrite,
  output logic [23:0] imm_ext,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_SW   = 4'd3;
  localparam logic [3:0] OP_BEQ  = 4'd4;
  localparam logic [3:0] OP_J    = 4'd5;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_e      state_q, state_d;
  logic [23:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;
  logic [3:0]  opcode;

  assign opcode = ir_q[23:20];

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = instr_in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_J:    state_d = S_FETCH;
          OP_HALT: state_d = S_HALT;
          OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_d = 1'b1;
            state_d   = S_HALT;
`else
            state_d   = S_FETCH;
`endif
          end
        endcase
      end
      S_EXEC: begin
        case (opcode)
          OP_BEQ:       state_d = S_FETCH;
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ir_q      <= 24'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Every output is forced low while reset is high, including FETCH's mem_read.
  always_comb begin
    Ra         = 3'd0;
    Rb         = 3'd0;
    Rw         = 3'd0;
    imm_ext    = 24'd0;
    alu_op     = 3'd0;
    alu_src    = 1'b0;
    enWrite    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      Ra      = ir_q[16:14];
      Rb      = (opcode == OP_R) ? ir_q[13:11] : ir_q[19:17];
      Rw      = ir_q[19:17];
      imm_ext = (opcode == OP_J) ? {4'b0, ir_q[19:0]} : {{10{ir_q[13]}}, ir_q[13:0]};
      alu_op  = (opcode == OP_R) ? ir_q[2:0] : ((opcode == OP_BEQ) ? 3'b001 : 3'b000);
      alu_src = (opcode == OP_ADDI) || (opcode == OP_LW) || (opcode == OP_SW);
      illegal = illegal_q;
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          pc_write = mem_ready;
        end
        S_DECODE: begin
          if (opcode == OP_J) begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
          end
        end
        S_EXEC: begin
          if (opcode == OP_BEQ) begin
            pc_write = alu_zero;
            pc_src   = 2'd1;
          end
        end
        S_MEM: begin
          mem_read  = (opcode == OP_LW);
          mem_write = (opcode == OP_SW);
        end
        S_WB: begin
          enWrite    = 1'b1;
          mem_to_reg = (opcode == OP_LW);
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - scoreboard bench for mc_control_unit
module tb_mc_control_unit;

  typedef struct packed {
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  rw;
    logic [23:0] imm;
    logic [2:0]  aop;
    logic        asrc;
    logic        enw;
    logic        pcw;
    logic [1:0]  pcs;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        hlt;
    logic        ill;
  } out_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] instr_in = 24'd0;
  logic        mem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic [2:0]  Ra, Rb, Rw, alu_op;
  logic        enWrite, pc_write, alu_src, mem_read, mem_write, mem_to_reg, halted, illegal;
  logic [23:0] imm_ext;
  logic [1:0]  pc_src;

  mc_control_unit dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .Ra(Ra), .Rb(Rb), .Rw(Rw), .enWrite(enWrite), .imm_ext(imm_ext), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  out_t got;
  assign got = {Ra, Rb, Rw, imm_ext, alu_op, alu_src, enWrite, pc_write, pc_src,
                mem_read, mem_write, mem_to_reg, halted, illegal};

  out_t exp_q[$];
  int   id_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   vec_id = 0;

  logic [2:0]  s_ra = 0, s_rb = 0, s_rw = 0, s_aop = 0;
  logic [23:0] s_imm = 0;
  logic        s_asrc = 0;
  logic        exp_ill = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t e;
      int   id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL vec%0d outputs got=%h expected=%h", id, got, e);
      end
    end
  end

  task automatic set_static(input logic [2:0] ra, rb, rw, input logic [23:0] imm,
                            input logic [2:0] aop, input logic asrc);
    s_ra = ra; s_rb = rb; s_rw = rw; s_imm = imm; s_aop = aop; s_asrc = asrc;
  endtask

  task automatic cyc(input logic rst, rdy, az, enw, pcw, input logic [1:0] pcs,
                     input logic mr, mw, m2r, hlt);
    out_t e;
    @(posedge clk);
    #1;
    reset = rst; mem_ready = rdy; alu_zero = az;
    e = '0;
    if (!rst) begin
      e.ra = s_ra; e.rb = s_rb; e.rw = s_rw; e.imm = s_imm; e.aop = s_aop; e.asrc = s_asrc;
      e.enw = enw; e.pcw = pcw; e.pcs = pcs; e.mr = mr; e.mw = mw; e.m2r = m2r;
      e.hlt = hlt; e.ill = exp_ill;
    end
    exp_q.push_back(e);
    id_q.push_back(vec_id);
    vec_id++;
  endtask

  task automatic do_reset();
    cyc(1, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    exp_ill = 0;
    set_static(0, 0, 0, 24'd0, 3'd0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // reset: IR=0 decodes as R-type with all-zero fields
    do_reset();
    do_reset();

    // R add rd=3 rs=1 rt=2 funct=0, mem_ready held high throughout
    instr_in = 24'h065000;
    cyc(0, 1, 0, 0, 1, 2'd0, 1, 0, 0, 0);
    set_static(3'd1, 3'd2, 3'd3, 24'h001000, 3'd0, 0);
    cyc(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 2'd0, 0, 0, 0, 0);

    // LW rd=5 rs=0 imm=0x3FFF, two wait cycles in MEM
    instr_in = 24'h2A3FFF;
    cyc(0, 1, 0, 0, 1, 2'd0, 1, 0, 0, 0);
    set_static(3'd0, 3'd5, 3'd5, 24'hFFFFFF, 3'd0, 1);
    cyc(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 2'd0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 2'd0, 0, 0, 1, 0);

    // BEQ rd=4 rs=6 imm=5, taken then not taken
    instr_in = 24'h498005;
    cyc(0, 1, 0, 0, 1, 2'd0, 1, 0, 0, 0);
    set_static(3'd6, 3'd4, 3'd4, 24'h000005, 3'd1, 0);
    cyc(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 2'd1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 2'd0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0);

    // J target=0x00ABC
    instr_in = 24'h500ABC;
    cyc(0, 1, 0, 0, 1, 2'd0, 1, 0, 0, 0);
    set_static(3'd0, 3'd0, 3'd0, 24'h000ABC, 3'd0, 0);
    cyc(0, 0, 0, 0, 1, 2'd2, 0, 0, 0, 0);

    // illegal opcode 9
    instr_in = 24'h929807;
    cyc(0, 1, 0, 0, 1, 2'd0, 1, 0, 0, 0);
    set_static(3'd2, 3'd1, 3'd1, 24'h001807, 3'd0, 0);
    cyc(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0);
`ifdef MC_ILLEGAL_TRAP_EN
    exp_ill = 1;
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 1);
`else
    cyc(0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0);
`endif
    do_reset();

    // SW rd=7 rs=3 imm=0x2000, reset during MEM wait
    instr_in = 24'h3EE000;
    cyc(0, 1, 0, 0, 1, 2'd0, 1, 0, 0, 0);
    set_static(3'd3, 3'd7, 3'd7, 24'hFFE000, 3'd0, 1);
    cyc(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0);

    // HALT, left only by reset
    instr_in = 24'hF00000;
    cyc(0, 1, 0, 0, 1, 2'd0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 1);
    do_reset();
    cyc(0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
